// File: rtl/aes_inv_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expansion
//   AES-128 inverse key schedule. The block loads the final round key and
//   walks the schedule backwards, one round per clock. It presents round keys
//   NUM_ROUNDS..0 to the inverse cipher over a valid/ready handshake.
//
//   Parameter
//     NUM_ROUNDS     index of the starting round key (1..10)
//   Ports
//     i_clk          clock, rising edge
//     i_rst          synchronous, active-high reset
//     i_start        load i_last_key and begin (honoured in IDLE only)
//     i_last_key     round-NUM_ROUNDS key, word 0 in [127:96]
//     i_key_ready    consumer accepts o_round_key this cycle
//     o_round_key    round key currently presented
//     o_round_index  round number of o_round_key
//     o_key_valid    o_round_key / o_round_index are valid
//     o_busy         high while the schedule is being emitted
//     o_done         one-cycle pulse after round key 0 is accepted
//   Optional (macro AES_INV_KEY_STORE_EN)
//     i_rd_addr      read address into the stored round keys
//     o_rd_key       registered read data; 0 for an out-of-range address
//
//   This file also holds AES_Sbox, the forward S-box used by the g-function.
// ---------------------------------------------------------------------------

module AES_Sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    // Forward AES S-box. Entry 0 is held in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_out = SBOX[(255 - int'(i_in)) * 8 +: 8];
endmodule

module aes_inv_key_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_last_key,
    input  logic         i_key_ready,
`ifdef AES_INV_KEY_STORE_EN
    input  logic [3:0]   i_rd_addr,
    output logic [127:0] o_rd_key,
`endif
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_index,
    output logic         o_key_valid,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic {S_IDLE, S_EMIT} state_t;

    // Forward Rcon[n]: 01 doubled in GF(2^8) n-1 times.
    function automatic logic [7:0] rcon_at(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < n; i++)
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        return r;
    endfunction

    localparam logic [3:0] START_IDX  = 4'(NUM_ROUNDS);
    localparam logic [7:0] START_RCON = rcon_at(NUM_ROUNDS);

    state_t       r_state;
    logic [127:0] r_round_key;
    logic [3:0]   r_round_index;
    logic [7:0]   r_rcon;
    logic         r_valid;
    logic         r_done;

    state_t       w_state_nxt;
    logic [127:0] w_key_nxt;
    logic [3:0]   w_idx_nxt;
    logic [7:0]   w_rcon_nxt;
    logic         w_done_nxt;
    logic         w_hs;

    // Backward step datapath
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_w0p, w_w1p, w_w2p, w_w3p;
    logic [31:0]  w_rot, w_sub;
    logic [127:0] w_prev_key;
    logic [7:0]   w_rcon_prev;

    assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;

    // The three high words un-chain with plain XORs. w0 then needs g() of the
    // recovered w3, so the S-boxes sit after the w3' XOR.
    assign w_w3p = w_w3 ^ w_w2;
    assign w_w2p = w_w2 ^ w_w1;
    assign w_w1p = w_w1 ^ w_w0;
    assign w_rot = {w_w3p[23:0], w_w3p[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        AES_Sbox u_sbox (
            .i_in  (w_rot[8*g +: 8]),
            .o_out (w_sub[8*g +: 8])
        );
    end

    assign w_w0p      = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};
    assign w_prev_key = {w_w0p, w_w1p, w_w2p, w_w3p};

    // Inverse of the GF(2^8) doubling: halve, and fold the reduction
    // polynomial back in when the low bit was set (36 -> 1B -> 80 -> ...).
    assign w_rcon_prev = (r_rcon >> 1) ^ (r_rcon[0] ? 8'h8d : 8'h00);

    assign w_hs = r_valid & i_key_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_round_key;
        w_idx_nxt   = r_round_index;
        w_rcon_nxt  = r_rcon;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_EMIT;
                    w_key_nxt   = i_last_key;
                    w_idx_nxt   = START_IDX;
                    w_rcon_nxt  = START_RCON;
                end
            end
            S_EMIT: begin
                if (w_hs) begin
                    if (r_round_index == 4'd0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_key_nxt  = w_prev_key;
                        w_idx_nxt  = r_round_index - 4'd1;
                        w_rcon_nxt = w_rcon_prev;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_round_key   <= '0;
            r_round_index <= '0;
            r_rcon        <= '0;
            r_valid       <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_round_key   <= w_key_nxt;
            r_round_index <= w_idx_nxt;
            r_rcon        <= w_rcon_nxt;
            r_valid       <= (w_state_nxt == S_EMIT);
            r_done        <= w_done_nxt;
        end
    end

    assign o_round_key   = r_round_key;
    assign o_round_index = r_round_index;
    assign o_key_valid   = r_valid;
    assign o_busy        = r_valid;
    assign o_done        = r_done;

`ifdef AES_INV_KEY_STORE_EN
    // Every accepted key is kept, so later decryptions can read round keys
    // without rerunning the schedule.
    logic [127:0] r_store [0:NUM_ROUNDS];
    logic [127:0] r_rd_key;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++)
                r_store[i] <= '0;
            r_rd_key <= '0;
        end else begin
            if (w_hs)
                r_store[r_round_index] <= r_round_key;
            if (i_rd_addr <= START_IDX)
                r_rd_key <= r_store[i_rd_addr];
            else
                r_rd_key <= '0;
        end
    end

    assign o_rd_key = r_rd_key;
`endif
endmodule

// File: tb/tb_aes_inv_key_expansion.sv
module tb_aes_inv_key_expansion;
    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] last_key;
    logic         key_ready;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;
    logic [127:0] round_key;
    logic [3:0]   round_index;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_tot = 0;
    int n_bad = 0;

    exp_t         exp_q[$];
    logic [127:0] sched [0:10];

    always #5 clk = ~clk;

    aes_inv_key_expansion #(.NUM_ROUNDS(10)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_last_key    (last_key),
        .i_key_ready   (key_ready),
`ifdef AES_INV_KEY_STORE_EN
        .i_rd_addr     (rd_addr),
        .o_rd_key      (rd_key),
`endif
        .o_round_key   (round_key),
        .o_round_index (round_index),
        .o_key_valid   (key_valid),
        .o_busy        (busy),
        .o_done        (done)
    );

`ifndef AES_INV_KEY_STORE_EN
    assign rd_key = '0;
`endif

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: forward FIPS-197 expansion with a computed S-box
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0]  inv = 8'h01;
        logic [15:0] bb;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        bb = {inv, inv};
        return inv ^ bb[14 -: 8] ^ bb[13 -: 8] ^ bb[12 -: 8] ^ bb[11 -: 8] ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = key0;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_a1();
        sched[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        sched[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        sched[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        sched[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        sched[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        sched[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        sched[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        sched[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        sched[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        sched[9]  = 128'hac7766f319fadc2128d12941575c006e;
        sched[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    endtask

    // ---- monitor: scoreboard pops on every handshake, stall stability
    logic         held = 1'b0;
    logic [127:0] held_key;
    logic [3:0]   held_idx;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (done) chk("done_excl_valid", 128'(key_valid), 128'd0);
            if (held) begin
                chk("stall_key", round_key, held_key);
                chk("stall_idx", 128'(round_index), 128'(held_idx));
            end
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 128'(round_index), 128'h0 - 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_idx", 128'(round_index), 128'(e.idx));
                    chk("sb_key", round_key, e.key);
                end
            end
            held     = key_valid && !key_ready;
            held_key = round_key;
            held_idx = round_index;
        end
    end

    // Push the schedule in sched[], start, run to done. Returns in the done
    // cycle so a following call gives a back-to-back start.
    task automatic run(input bit bp, input bit inj);
        int n = 0;
        int lows = 0;
        int k = 0;
        for (int i = 10; i >= 0; i--) exp_q.push_back('{idx: 4'(i), key: sched[i]});
        last_key  = sched[10];
        start     = 1'b1;
        key_ready = 1'b1;
        cyc();
        start    = 1'b0;
        last_key = ~sched[10];
        chk("start_valid", 128'(key_valid), 128'd1);
        chk("start_busy", 128'(busy), 128'd1);
        chk("start_idx", 128'(round_index), 128'd10);
        chk("start_done", 128'(done), 128'd0);
        while (!done && n < 100) begin
            key_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            k++;
            if (key_valid && !key_ready) lows++;
            start = (inj && n == 3);
            cyc();
            n++;
        end
        start = 1'b0;
        chk("done_latency", 128'(n), 128'(11 + lows));
        chk("end_busy", 128'(busy), 128'd0);
        chk("end_valid", 128'(key_valid), 128'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        last_key  = '0;
        key_ready = 1'b0;
        rd_addr   = '0;
        repeat (3) cyc();
        chk("rst_key", round_key, 128'd0);
        chk("rst_idx", 128'(round_index), 128'd0);
        chk("rst_valid", 128'(key_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        rst = 1'b0;
        cyc();

        // FIPS-197 A.1, no backpressure
        load_a1();
        run(1'b0, 1'b0);

`ifdef AES_INV_KEY_STORE_EN
        rd_addr = 4'd0;
        cyc();
        chk("rd_key0", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_addr = 4'd10;
        cyc();
        chk("rd_key10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_addr = 4'd12;
        cyc();
        chk("rd_oor", rd_key, 128'd0);
`endif
        cyc();

        // backpressure, then back-to-back runs with a stray start in EMIT
        load_a1();
        run(1'b1, 1'b0);
        expand({$urandom, $urandom, $urandom, $urandom});
        run(1'b0, 1'b1);
        expand({$urandom, $urandom, $urandom, $urandom});
        run(1'b1, 1'b1);

        // reset mid-schedule at index 5
        cyc();
        load_a1();
        for (int i = 10; i >= 0; i--) exp_q.push_back('{idx: 4'(i), key: sched[i]});
        last_key  = sched[10];
        start     = 1'b1;
        key_ready = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (round_index != 4'd5 && n < 30) begin
            cyc();
            n++;
        end
        chk("reach_idx5", 128'(round_index), 128'd5);
        rst = 1'b1;
        cyc();
        chk("mid_rst_key", round_key, 128'd0);
        chk("mid_rst_idx", 128'(round_index), 128'd0);
        chk("mid_rst_valid", 128'(key_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_done", 128'(done), 128'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (2) begin
            cyc();
            chk("post_rst_done", 128'(done), 128'd0);
            chk("post_rst_valid", 128'(key_valid), 128'd0);
        end

        // full run after the abandoned one
        expand(128'h000102030405060708090a0b0c0d0e0f);
        run(1'b0, 1'b0);
        repeat (3) cyc();
        chk("sb_left", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_inv_key_expansion.md
# aes_inv_key_expansion

AES-128 inverse key-schedule engine for the decryption datapath. It takes the final (round-10) round key and walks the key schedule backwards, one round per clock, presenting round keys 10, 9, …, 0 to the inverse-cipher core through a valid/ready handshake. Each backward step reuses four `AES_Sbox` instances and the g-function rotate/substitute/Rcon structure, but the Rcon runs in reverse.

## Interface
- `NUM_ROUNDS`, default 10. Index of the starting round key. Legal range is 1..10. The starting Rcon is Rcon[`NUM_ROUNDS`].
- `clk` input 1: the single clock. Every flop is clocked on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: load `last_key` and begin. Honoured only in IDLE.
- `last_key` input 128: round-`NUM_ROUNDS` key. Word 0 is bits [127:96]; the MSB byte comes first within each word.
- `round_key` output 128: the round key currently presented.
- `round_index` output 4: round number of `round_key`.
- `key_valid` output 1: `round_key` and `round_index` are valid.
- `key_ready` input 1: the consumer accepts the key this cycle.
- `busy` output 1: high while in EMIT.
- `done` output 1: one-cycle pulse after round key 0 is accepted.

## Operation
- States are IDLE and EMIT.
- IDLE → EMIT when `start` is high:
  - `round_key` ← `last_key`
  - `round_index` ← `NUM_ROUNDS`
  - `rcon` ← Rcon[`NUM_ROUNDS`]
- EMIT, handshake (`key_valid` & `key_ready`) with `round_index` ≠ 0: load the previous round key, `round_index` ← `round_index` − 1, and step `rcon` back.
- EMIT, handshake with `round_index` = 0: go to IDLE and pulse `done` in the next cycle.
- EMIT without a handshake: hold every output stable.
- Backward step. Let w0..w3 be the current key and w0'..w3' the previous one:
  - w3' = w3 ^ w2
  - w2' = w2 ^ w1
  - w1' = w1 ^ w0
  - w0' = w0 ^ g(w3')
  - g(x) = SubWord(RotWord(x)) ^ {rcon, 24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
- Rcon step-back, 8-bit: `rcon_prev` = (`rcon` >> 1) ^ (`rcon`[0] ? 8'h8D : 8'h00). This gives the sequence 36→1B→80→40→…→02→01.
- The Rcon used for a step is the one belonging to the current `round_index`.
- `start` while in EMIT is ignored; `last_key` is not re-sampled.
- `start` in the same cycle as the `done` pulse is accepted, because the block is already in IDLE.
- `rst`, in any state:
  - next cycle: state IDLE
  - `round_key` = 0, `round_index` = 0, `rcon` = 0
  - `key_valid` = 0, `busy` = 0, `done` = 0
  - an in-flight schedule is abandoned with no `done`.

## Timing
- All outputs are registered.
- `key_valid` and `busy` rise in the cycle after `start` is sampled, with round key `NUM_ROUNDS` already present.
- Each backward step is a single cycle: the S-box and XOR path is combinational between the output register and its next-state logic.
- With `key_ready` held high, the keys occupy `NUM_ROUNDS`+1 consecutive cycles, and `done` follows in the next cycle. From `start` to `done` is `NUM_ROUNDS`+2 cycles.
- `key_ready` low in a cycle adds exactly one cycle of stall per low cycle. The key is held unchanged during the stall.
- `done` is never asserted together with `key_valid`.

## Configuration
- `AES_INV_KEY_STORE_EN` defined:
  - Adds a `NUM_ROUNDS`+1 entry × 128 register file. Entry `round_index` is written on each handshake.
  - Adds input `rd_addr` [3:0] and output `rd_key` [127:0]. `rd_key` is registered, so the read takes one cycle.
  - Out-of-range `rd_addr` returns 0. Entries are cleared by `rst`.
  - This allows repeated decryptions without rerunning the schedule.
- Undefined: neither the store nor the `rd_*` ports exist. The block is streaming only.

## Test plan
- FIPS-197 A.1 key, `NUM_ROUNDS`=10, `last_key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `key_ready`=1:
  - index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - index 9 = ac7766f319fadc2128d12941575c006e
  - index 0 = 2b7e151628aed2a6abf7158809cf4f3c
  - `done` at cycle 12 after `start`.
- Backpressure: `key_ready` toggling 1,0,0,1,…
  - keys and indices are held stable while `key_ready` is low
  - same key sequence as above
  - `done` is delayed by exactly the number of low cycles.
- `start` pulsed in EMIT with a different `last_key` → ignored; sequence unchanged.
- `rst` asserted at index 5 → next cycle all outputs 0 and state IDLE, no `done`. A new `start` then gives a correct full sequence.
- Back-to-back: `start` during the `done` cycle → `key_valid` rises the next cycle with the new key at index 10.
- With `AES_INV_KEY_STORE_EN`: after the A.1 run, `rd_addr`=0 gives `rd_key`=2b7e1516…4f3c one cycle later, and `rd_addr`=12 gives 0.
